argmax_classifier: RTL and testbench

Final stage of the LeNet inference path, directly downstream of the layer-3 ReLU activation. Captures the 10-element ReLU'd class score vector with a valid/ready handshake. Scans it sequentially, one element per cycle, to find the winning class. Presents the class index and its score on a registered output handshake.

---
 rtl/lenet_pkg.sv | 9 +
 rtl/argmax_update.sv | 26 ++
 rtl/argmax_classifier.sv | 91 +++++++++
 tb/tb_argmax_classifier.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg: shared score types, sizing constants and argmax FSM states for the LeNet back end.
package lenet_pkg;
  localparam int bitwidth = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W = 4;
  typedef logic signed [bitwidth-1:0] score_t;
  typedef score_t [NUM_CLASSES-1:0] score_vec_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;
endpackage

// File: rtl/argmax_update.sv
// argmax_update: combinational compare/update cell for one candidate score.
// ARGMAX_MARGIN_EN adds second-best tracking.
module argmax_update #(
  parameter int bitwidth = 16,
  parameter int IDX_W = 4
) (
  input  logic signed [bitwidth-1:0] best,
  input  logic        [IDX_W-1:0]    best_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [bitwidth-1:0] second,
  output logic signed [bitwidth-1:0] nsecond,
`endif
  input  logic signed [bitwidth-1:0] cand,
  input  logic        [IDX_W-1:0]    cand_idx,
  output logic signed [bitwidth-1:0] nbest,
  output logic        [IDX_W-1:0]    nbest_idx
);
  logic gt;
  // strict compare keeps the lower index on ties
  assign gt = cand > best;
  assign nbest = gt ? cand : best;
  assign nbest_idx = gt ? cand_idx : best_idx;
`ifdef ARGMAX_MARGIN_EN
  assign nsecond = gt ? best : (cand > second ? cand : second);
`endif
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: captures a class score vector and scans it one element per cycle for the winner.
// ARGMAX_MARGIN_EN adds the class_margin output (best minus second-best).
module argmax_classifier import lenet_pkg::*; #(
  parameter int bitwidth = lenet_pkg::bitwidth,
  parameter int NUM_CLASSES = lenet_pkg::NUM_CLASSES,
  parameter int IDX_W = lenet_pkg::IDX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [bitwidth-1:0] featuremap [NUM_CLASSES-1:0],
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [IDX_W-1:0]    class_idx,
  output logic signed [bitwidth-1:0] class_score,
`ifdef ARGMAX_MARGIN_EN
  output logic        [bitwidth-1:0] class_margin,
`endif
  output logic                       busy
);
  argmax_state_t state, state_nxt;
  logic signed [bitwidth-1:0] bank [NUM_CLASSES-1:0];
  logic signed [bitwidth-1:0] best, nbest;
  logic [IDX_W-1:0] best_idx, nbest_idx, cnt;
  logic last;
`ifdef ARGMAX_MARGIN_EN
  logic signed [bitwidth-1:0] second, nsecond;
`endif
  assign last = cnt == IDX_W'(NUM_CLASSES-1);
  argmax_update #(.bitwidth(bitwidth), .IDX_W(IDX_W)) u_upd (
    .best(best),
    .best_idx(best_idx),
`ifdef ARGMAX_MARGIN_EN
    .second(second),
    .nsecond(nsecond),
`endif
    .cand(bank[cnt]),
    .cand_idx(cnt),
    .nbest(nbest),
    .nbest_idx(nbest_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && in_valid) ? SCAN :
                (state == SCAN && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
      best <= '0;
      best_idx <= '0;
      cnt <= '0;
      class_idx <= '0;
      class_score <= '0;
`ifdef ARGMAX_MARGIN_EN
      second <= '0;
      class_margin <= '0;
`endif
    end else if (state == IDLE && in_valid) begin
      bank <= featuremap;
      best <= featuremap[0];
      best_idx <= '0;
      cnt <= IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
      second <= {1'b1, {(bitwidth-1){1'b0}}};
`endif
    end else if (state == SCAN) begin
      best <= nbest;
      best_idx <= nbest_idx;
      cnt <= last ? cnt : cnt + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
      second <= nsecond;
`endif
      if (last) begin
        class_idx <= nbest_idx;
        class_score <= nbest;
`ifdef ARGMAX_MARGIN_EN
        class_margin <= nbest - nsecond;
`endif
      end
    end
  end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed self-checking bench for argmax_classifier.
module tb_argmax_classifier;
  logic clk = 0;
  logic rst_n = 0;
  logic signed [15:0] fm [9:0];
  logic in_valid = 0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1;
  logic [3:0] class_idx;
  logic signed [15:0] class_score;
  logic busy;
`ifdef ARGMAX_MARGIN_EN
  logic [15:0] class_margin;
`endif
  int total = 0;
  int bad = 0;

  argmax_classifier dut (
    .clk(clk),
    .rst_n(rst_n),
    .featuremap(fm),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .class_idx(class_idx),
    .class_score(class_score),
`ifdef ARGMAX_MARGIN_EN
    .class_margin(class_margin),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send(input int v[10]);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (!in_ready) begin bad++; $display("FAIL send_ready in_ready=%0b want 1", in_ready); end
    for (int i = 0; i < 10; i++) fm[i] = 16'(v[i]);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctl in_ready=%0b out_valid=%0b busy=%0b want 1 0 0", in_ready, out_valid, busy);
    end
    total++;
    if (class_idx !== 4'd0 || class_score !== 16'sd0) begin
      bad++; $display("FAIL reset_out idx=%0d score=%0d want 0 0", class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd0) begin bad++; $display("FAIL reset_margin got=%0d want 0", class_margin); end
`endif
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n;
    send('{0, 5, 3, 9, 1, 0, 2, 7, 4, 6});
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_busy busy=%0b in_ready=%0b want 1 0", busy, in_ready);
    end
    wait_out(n);
    total++;
    if (n != 9) begin bad++; $display("FAIL basic_latency got=%0d want 9", n); end
    total++;
    if (class_idx !== 4'd3 || class_score !== 16'sd9) begin
      bad++; $display("FAIL basic_result idx=%0d score=%0d want 3 9", class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd2) begin bad++; $display("FAIL basic_margin got=%0d want 2", class_margin); end
`endif
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_release out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zeros;
    int n;
    send('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    wait_out(n);
    total++;
    if (n != 9 || class_idx !== 4'd0 || class_score !== 16'sd0) begin
      bad++; $display("FAIL zeros n=%0d idx=%0d score=%0d want 9 0 0", n, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd0) begin bad++; $display("FAIL zeros_margin got=%0d want 0", class_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_tie;
    int n;
    send('{1, 1, 8, 1, 1, 1, 8, 1, 1, 1});
    wait_out(n);
    total++;
    if (n != 9 || class_idx !== 4'd2 || class_score !== 16'sd8) begin
      bad++; $display("FAIL tie n=%0d idx=%0d score=%0d want 9 2 8", n, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd0) begin bad++; $display("FAIL tie_margin got=%0d want 0", class_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_negative;
    int n;
    send('{-5, -3, -7, -4, -9, -8, -6, -10, -11, -20});
    wait_out(n);
    total++;
    if (n != 9 || class_idx !== 4'd1 || class_score !== -16'sd3) begin
      bad++; $display("FAIL negative n=%0d idx=%0d score=%0d want 9 1 -3", n, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd1) begin bad++; $display("FAIL negative_margin got=%0d want 1", class_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n;
    int ok;
    out_ready = 0;
    send('{0, 5, 3, 9, 1, 0, 2, 7, 4, 6});
    wait_out(n);
    total++;
    if (n != 9) begin bad++; $display("FAIL bp_latency got=%0d want 9", n); end
    for (int i = 0; i < 9; i++) fm[i] = 16'(i + 1);
    fm[9] = 16'sh7FFF;
    in_valid = 1;
    ok = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || class_idx !== 4'd3 || class_score !== 16'sd9) ok = 0;
    end
    total++;
    if (ok == 0) begin
      bad++; $display("FAIL bp_hold out_valid=%0b in_ready=%0b idx=%0d score=%0d want 1 0 3 9", out_valid, in_ready, class_idx, class_score);
    end
    out_ready = 1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_handshake out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bp_accept busy=%0b want 1", busy); end
    wait_out(n);
    total++;
    if (n != 9 || class_idx !== 4'd9 || class_score !== 16'sd32767) begin
      bad++; $display("FAIL bp_second n=%0d idx=%0d score=%0d want 9 9 32767", n, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd32758) begin bad++; $display("FAIL bp_margin got=%0d want 32758", class_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_midscan_reset;
    int n;
    int seen;
    send('{0, 5, 3, 9, 1, 0, 2, 7, 4, 6});
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || class_idx !== 4'd0 || class_score !== 16'sd0) begin
      bad++; $display("FAIL rst_mid in_ready=%0b out_valid=%0b busy=%0b idx=%0d score=%0d want 1 0 0 0 0", in_ready, out_valid, busy, class_idx, class_score);
    end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_no_result seen=%0d want 0", seen); end
    send('{12, 3, 4, 5, 6, 7, 8, 9, 10, 11});
    wait_out(n);
    total++;
    if (n != 9 || class_idx !== 4'd0 || class_score !== 16'sd12) begin
      bad++; $display("FAIL rst_fresh n=%0d idx=%0d score=%0d want 9 0 12", n, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    total++;
    if (class_margin !== 16'd1) begin bad++; $display("FAIL rst_margin got=%0d want 1", class_margin); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_capture;
    int n;
    send('{0, 5, 3, 9, 1, 0, 2, 7, 4, 6});
    for (int i = 0; i < 10; i++) fm[i] = 16'sh7FFF;
    wait_out(n);
    total++;
    if (n != 9 || class_idx !== 4'd3 || class_score !== 16'sd9) begin
      bad++; $display("FAIL capture n=%0d idx=%0d score=%0d want 9 3 9", n, class_idx, class_score);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) fm[i] = 16'sd0;
    test_reset;
    test_basic;
    test_zeros;
    test_tie;
    test_negative;
    test_backpressure;
    test_midscan_reset;
    test_capture;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
